// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive engine: FSM state encoding,
// character width, data_bits encoding and default oversample ratio.
package uart_rx_pkg;

  localparam int UART_DATA_W = 8;
  localparam int DEFAULT_OSR = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP1,
    S_STOP2
  } rx_state_t;

  // data_bits field: 0..3 selects 5..8 data bits
  typedef enum logic [1:0] {
    DB_5 = 2'd0,
    DB_6 = 2'd1,
    DB_7 = 2'd2,
    DB_8 = 2'd3
  } data_bits_t;

  // Index of the last data bit of a frame (4..7 for 5..8 bits)
  function automatic logic [2:0] last_bit_idx(input data_bits_t db);
    return {1'b1, db};
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchroniser for the asynchronous rxd line. The chain resets
// to 1 so that the line reads as idle while reset is released.
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rxd,
  output logic rxs
);

  logic [SYNC_STAGES-1:0] sync_q;

  // Shift rxd through the synchroniser chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '1;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
  end

  assign rxs = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receive engine: start detection, mid-bit sampling, parity and stop
// checks, one-entry valid/ready holding register and sticky error flags.
// Optional build macro UART_RX_MAJORITY_EN: each bit is the 2-of-3 majority
// of three consecutive ticks around mid-bit, decided on the last of them.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int OSR         = DEFAULT_OSR,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rx_en,
  input  logic                   rx_data_sample,
  input  logic                   rxd,
  input  logic [1:0]             data_bits,
  input  logic                   parity_en,
  input  logic                   parity_odd,
  input  logic                   stop2,
  output logic [UART_DATA_W-1:0] rx_data,
  output logic                   rx_valid,
  input  logic                   rx_ready,
  output logic                   parity_err,
  output logic                   frame_err,
  output logic                   overrun_err,
  output logic                   break_det,
  input  logic                   err_clr,
  output logic                   busy
);

  localparam int CW = $clog2(OSR);
  localparam logic [CW-1:0] BIT_LAST = CW'(OSR - 1);

  logic                   rxs;
  logic                   tick;
  logic                   bit_val;
  logic                   at_dec;
  logic                   fin;
  logic                   accept;
  rx_state_t              state;
  logic [CW-1:0]          tick_cnt;
  logic [2:0]             bit_cnt;
  logic [UART_DATA_W-1:0] shreg;
  data_bits_t             db_r;
  logic                   pen_r;
  logic                   podd_r;
  logic                   st2_r;
  logic                   par_bad;
  logic                   frm_bad;
  logic                   all_zero;
  logic                   cmp_vld;
  logic [UART_DATA_W-1:0] cmp_data;
  logic                   cmp_par;
  logic                   cmp_frm;
  logic                   cmp_brk;

  uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .rxd   (rxd),
    .rxs   (rxs)
  );

  assign tick = rx_en & rx_data_sample;

`ifdef UART_RX_MAJORITY_EN
  // START decides two ticks past mid-bit so all three votes are in
  localparam logic [CW-1:0] START_DEC = CW'(OSR / 2 + 1);
  logic [1:0] maj_sh;

  // Keep the two previous tick samples of rxs for the majority vote
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    maj_sh <= 2'b11;
    else if (tick) maj_sh <= {maj_sh[0], rxs};
  end

  assign bit_val = (maj_sh[1] & maj_sh[0]) | (maj_sh[1] & rxs) | (maj_sh[0] & rxs);
`else
  localparam logic [CW-1:0] START_DEC = CW'(OSR / 2 - 1);
  assign bit_val = rxs;
`endif

  // START decides at half a bit; later bits decide one full bit later
  assign at_dec = tick && (tick_cnt == ((state == S_START) ? START_DEC : BIT_LAST));
  assign fin    = at_dec && (((state == S_STOP1) && !st2_r) || (state == S_STOP2));
  assign accept = rx_valid & rx_ready;
  assign busy   = (state != S_IDLE);

  // Receive FSM with tick/bit counters, shift register and frame marks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      db_r     <= DB_8;
      pen_r    <= 1'b0;
      podd_r   <= 1'b0;
      st2_r    <= 1'b0;
      par_bad  <= 1'b0;
      frm_bad  <= 1'b0;
      all_zero <= 1'b0;
    end else if (!rx_en) begin
      state    <= S_IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
    end else if (tick) begin
      case (state)
        S_IDLE: begin
          if (!rxs) begin
            state    <= S_START;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            db_r     <= data_bits_t'(data_bits);
            pen_r    <= parity_en;
            podd_r   <= parity_odd;
            st2_r    <= stop2;
            par_bad  <= 1'b0;
            frm_bad  <= 1'b0;
            all_zero <= 1'b1;
          end
        end
        S_START: begin
          if (at_dec) begin
            tick_cnt <= '0;
            state    <= bit_val ? S_IDLE : S_DATA;
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (at_dec) begin
            tick_cnt       <= '0;
            shreg[bit_cnt] <= bit_val;
            if (bit_val) all_zero <= 1'b0;
            if (bit_cnt == last_bit_idx(db_r)) begin
              bit_cnt <= '0;
              state   <= pen_r ? S_PARITY : S_STOP1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        S_PARITY: begin
          if (at_dec) begin
            tick_cnt <= '0;
            if (bit_val != ((^shreg) ^ podd_r)) par_bad <= 1'b1;
            if (bit_val) all_zero <= 1'b0;
            state <= S_STOP1;
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        S_STOP1, S_STOP2: begin
          if (at_dec) begin
            tick_cnt <= '0;
            if (!bit_val) frm_bad <= 1'b1;
            else          all_zero <= 1'b0;
            state <= (state == S_STOP1 && st2_r) ? S_STOP2 : S_IDLE;
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Capture the finished character and its marks, including the last stop sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_vld  <= 1'b0;
      cmp_data <= '0;
      cmp_par  <= 1'b0;
      cmp_frm  <= 1'b0;
      cmp_brk  <= 1'b0;
    end else begin
      cmp_vld <= fin;
      if (fin) begin
        cmp_data <= shreg;
        cmp_par  <= par_bad;
        cmp_frm  <= frm_bad | ~bit_val;
        cmp_brk  <= all_zero & ~bit_val;
      end
    end
  end

  // Holding register handshake and sticky flags; a set event beats err_clr
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
      break_det   <= 1'b0;
    end else begin
      if (cmp_vld) begin
        if (!rx_valid || accept) begin
          rx_data  <= cmp_data;
          rx_valid <= 1'b1;
        end
      end else if (accept) begin
        rx_valid <= 1'b0;
      end
      if (err_clr) begin
        parity_err  <= 1'b0;
        frame_err   <= 1'b0;
        overrun_err <= 1'b0;
        break_det   <= 1'b0;
      end
      if (cmp_vld) begin
        if (cmp_par)           parity_err  <= 1'b1;
        if (cmp_frm | cmp_brk) frame_err   <= 1'b1;
        if (cmp_brk)           break_det   <= 1'b1;
        if (rx_valid && !accept) overrun_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at OSR=16 with the oversample tick tied high.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_en = 1'b0;
  logic       rx_data_sample = 1'b1;
  logic       rxd = 1'b1;
  logic [1:0] data_bits = 2'd3;
  logic       parity_en = 1'b0;
  logic       parity_odd = 1'b0;
  logic       stop2 = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       parity_err;
  logic       frame_err;
  logic       overrun_err;
  logic       break_det;
  logic       err_clr = 1'b0;
  logic       busy;

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  logic [7:0] exp_q[$];

  uart_rx #(.OSR(16), .SYNC_STAGES(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rx_en          (rx_en),
    .rx_data_sample (rx_data_sample),
    .rxd            (rxd),
    .data_bits      (data_bits),
    .parity_en      (parity_en),
    .parity_odd     (parity_odd),
    .stop2          (stop2),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
    .parity_err     (parity_err),
    .frame_err      (frame_err),
    .overrun_err    (overrun_err),
    .break_det      (break_det),
    .err_clr        (err_clr),
    .busy           (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_flags(input string name, input logic [3:0] exp);
    check(name, {28'd0, parity_err, frame_err, overrun_err, break_det}, {28'd0, exp});
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Cycles from driving the start bit to rx_valid visible, for n bits after start:
  // 2 sync flops + 1 detect + half-bit decision + 16 per further bit + 1 load
  function automatic int lat(input int n);
`ifdef UART_RX_MAJORITY_EN
    return 3 + 10 + 16 * n + 1;
`else
    return 3 + 8 + 16 * n + 1;
`endif
  endfunction

  // Drive one frame; flip inverts the line for one cycle at each bit centre
  task automatic send_frame(input logic [7:0] d, input int nb, input bit pen, input bit pbit,
                            input int ns, input bit sv, input bit flip);
    logic b;
    int   tot;
    tot = 1 + nb + int'(pen) + ns;
    for (int j = 0; j < tot; j++) begin
      if (j == 0)                  b = 1'b0;
      else if (j <= nb)            b = d[j-1];
      else if (pen && j == nb + 1) b = pbit;
      else                         b = sv;
      for (int k = 0; k < 16; k++) begin
        rxd = (flip && k == 8) ? ~b : b;
        tick_n(1);
      end
    end
    rxd = 1'b1;
  endtask

  task automatic wait_valid(input int max, output int at);
    at = -1;
    for (int i = 0; i < max; i++) begin
      tick_n(1);
      if (rx_valid) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      checks++;
      failures++;
      $display("FAIL wait_valid timeout actual=0 required=1");
    end
  endtask

  task automatic drain();
    rx_ready = 1'b1;
    tick_n(1);
    rx_ready = 1'b0;
    check("valid_after_drain", {31'd0, rx_valid}, 32'd0);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    tick_n(1);
    err_clr = 1'b0;
  endtask

  // Monitor: every accepted character is compared against the scoreboard
  always @(negedge clk) begin
    if (rst_n && rx_valid && rx_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_char actual=%0h required=none", rx_data);
      end else begin
        check("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    int c0;
    int at;

    // Reset state
    tick_n(3);
    check("rst_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_data", {24'd0, rx_data}, 32'd0);
    check_flags("rst_flags", 4'b0000);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    rx_en = 1'b1;
    tick_n(10);

    // 8N1 0xA5: latency and clean flags
    exp_q.push_back(8'hA5);
    c0 = cyc;
    fork
      send_frame(8'hA5, 8, 1'b0, 1'b0, 1, 1'b1, 1'b0);
      wait_valid(400, at);
    join
    check("latency_8n1", at - c0, lat(9));
    check_flags("flags_a5", 4'b0000);
    drain();
    tick_n(20);

    // 7E1 0x41 with wrong parity bit
    data_bits = 2'd2;
    parity_en = 1'b1;
    exp_q.push_back(8'h41);
    fork
      send_frame(8'h41, 7, 1'b1, 1'b1, 1, 1'b1, 1'b0);
      wait_valid(400, at);
    join
    check_flags("flags_parity", 4'b1000);
    drain();
    pulse_clr();
    check_flags("flags_par_clr", 4'b0000);
    data_bits = 2'd3;
    parity_en = 1'b0;
    tick_n(20);

    // 8N1 0x3C with stop bit low: framing error only
    exp_q.push_back(8'h3C);
    fork
      send_frame(8'h3C, 8, 1'b0, 1'b0, 1, 1'b0, 1'b0);
      wait_valid(400, at);
    join
    tick_n(40);
    check_flags("flags_frame", 4'b0100);
    drain();
    pulse_clr();

    // All-zero frame including stop: break
    exp_q.push_back(8'h00);
    fork
      send_frame(8'h00, 8, 1'b0, 1'b0, 1, 1'b0, 1'b0);
      wait_valid(400, at);
    join
    tick_n(40);
    check_flags("flags_break", 4'b0101);
    drain();
    pulse_clr();
    check_flags("flags_brk_clr", 4'b0000);
    tick_n(20);

    // 6-cycle glitch: false start
    rxd = 1'b0;
    tick_n(6);
    rxd = 1'b1;
    check("glitch_busy_hi", {31'd0, busy}, 32'd1);
    tick_n(30);
    check("glitch_busy_lo", {31'd0, busy}, 32'd0);
    check("glitch_valid", {31'd0, rx_valid}, 32'd0);
    check_flags("glitch_flags", 4'b0000);

    // Two 8N2 frames, not consumed: overrun keeps 0x11
    stop2 = 1'b1;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 8, 1'b0, 1'b0, 2, 1'b1, 1'b0);
    send_frame(8'h22, 8, 1'b0, 1'b0, 2, 1'b1, 1'b0);
    tick_n(20);
    check_flags("flags_overrun", 4'b0010);
    check("ovr_valid", {31'd0, rx_valid}, 32'd1);
    drain();
    pulse_clr();
    tick_n(20);

    // Same pair, ready pulsed exactly in the second completion cycle
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    c0 = cyc;
    fork
      begin
        send_frame(8'h11, 8, 1'b0, 1'b0, 2, 1'b1, 1'b0);
        send_frame(8'h22, 8, 1'b0, 1'b0, 2, 1'b1, 1'b0);
      end
      begin
        for (int i = 0; i < 1000 && cyc < c0 + 176 + lat(10) - 1; i++) tick_n(1);
        rx_ready = 1'b1;
        tick_n(1);
        rx_ready = 1'b0;
      end
    join
    tick_n(10);
    check_flags("flags_no_ovr", 4'b0000);
    check("hs_valid", {31'd0, rx_valid}, 32'd1);
    drain();
    stop2 = 1'b0;
    tick_n(20);

    // rx_en dropped mid-DATA of 0xFF: nothing delivered
    fork
      send_frame(8'hFF, 8, 1'b0, 1'b0, 1, 1'b1, 1'b0);
      begin
        tick_n(70);
        check("en_busy_hi", {31'd0, busy}, 32'd1);
        rx_en = 1'b0;
        tick_n(5);
        check("en_busy_lo", {31'd0, busy}, 32'd0);
        rx_en = 1'b1;
      end
    join
    tick_n(40);
    check("en_valid", {31'd0, rx_valid}, 32'd0);
    check_flags("en_flags", 4'b0000);

    // Full 0x5A afterwards
    exp_q.push_back(8'h5A);
    fork
      send_frame(8'h5A, 8, 1'b0, 1'b0, 1, 1'b1, 1'b0);
      wait_valid(400, at);
    join
    drain();
    tick_n(20);

`ifdef UART_RX_MAJORITY_EN
    // One-cycle flip at every bit centre is voted out
    exp_q.push_back(8'h5A);
    fork
      send_frame(8'h5A, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1);
      wait_valid(400, at);
    join
    check_flags("maj_flags", 4'b0000);
    drain();
    tick_n(20);
`endif

    check("queue_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
